audio_clamp_scheduler: RTL
==========================

// Module: audio_clamp_scheduler
// PURPOSE
//  Shares one combinational sample-clamp datapath between the left and right audio channels.
//  Round-robin arbitration over two valid/ready sample sources; drives the clamp with the sample and limits.
//  Registers the clamped result into a one-entry output buffer with backpressure.
//  Owns the clamp limit configuration and a saturation-event counter.
// PARAMETERS
//  DATA_W  32  sample width (unsigned)
//  DEF_LO  11  clamp low limit after reset
//  DEF_HI  22  clamp high limit after reset
//  CNT_W   16  saturation counter width
// PORTS
//  CLOCK_50   in   1       system clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low reset
//  l_valid    in   1       left sample available
//  l_data     in   DATA_W  left sample
//  l_ready    out  1       left sample accepted this cycle when l_valid&l_ready
//  r_valid    in   1       right sample available
//  r_data     in   DATA_W  right sample
//  r_ready    out  1       right sample accepted this cycle when r_valid&r_ready
//  cfg_wr     in   1       one-cycle strobe: load cfg_lo/cfg_hi
//  cfg_lo     in   DATA_W  requested low limit
//  cfg_hi     in   DATA_W  requested high limit
//  cfg_err    out  1       sticky: a write with cfg_lo>cfg_hi was rejected
//  clamp_in   out  DATA_W  sample to shared clamp datapath
//  clamp_lo   out  DATA_W  active low limit to clamp
//  clamp_hi   out  DATA_W  active high limit to clamp
//  clamp_out  in   DATA_W  clamp result (combinational from clamp_in/lo/hi)
//  out_valid  out  1       output buffer full
//  out_data   out  DATA_W  clamped sample
//  out_chan   out  1       0=left 1=right
//  out_ready  in   1       downstream takes output when out_valid&out_ready
//  sat_count  out  CNT_W   number of accepted samples the clamp altered
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_chan=0, sat_count=0, cfg_err=0, active lo/hi=DEF_LO/DEF_HI,
//   no pending config, rr pointer=left-favoured (last_served=right); l_ready=r_ready=0 in reset.
//  Buffer FSM: EMPTY <-> FULL. slot_free = EMPTY | (FULL & out_ready).
//   EMPTY: grant -> FULL. FULL: out_ready&!grant -> EMPTY; out_ready&grant -> FULL (new data); else hold.
//  Arbiter (comb): grant only if slot_free. Only one valid -> that channel.
//   Both valid -> channel != last_served. l_ready/r_ready = grant to that channel (at most one high).
//   last_served updates on every accepted sample.
//  Datapath: clamp_in = granted channel's data (l_data when no grant).
//   Accept at edge N -> out_data=clamp_out, out_chan set, out_valid=1 at N+1 (latency 1, throughput 1/clk).
//  FULL & !out_ready: out_data/out_chan stable, no ready asserted, sources must hold.
//  Saturation: on accept, if clamp_out != clamp_in, sat_count+=1; holds at all-ones (no wrap).
//  Config: cfg_wr with cfg_lo<=cfg_hi (unsigned) -> shadow latched, pending=1; cfg_lo>cfg_hi -> ignored,
//   cfg_err=1 (clears only on reset). Pending shadow copies to active limits at first edge with no accept
//   (may be the cfg_wr edge itself); sample accepted same cycle as cfg_wr uses old limits.
//   A second cfg_wr while pending overwrites the shadow (last write wins).
//  Reset mid-operation: buffered sample discarded, limits return to defaults, no output glitch after release.
// TESTING
//  Reset, l_valid=1 l_data=5 -> l_ready=1; next cycle out_valid=1 out_data=11 out_chan=0 sat_count=1.
//  l and r valid every cycle, out_ready=1, data 15/40 -> out_chan alternates 0,1,0..; data 15,22; 1 sample/clk.
//  out_ready=0 with buffer full for 4 cycles -> l_ready=r_ready=0, out_data stable; release -> resumes, none lost.
//  cfg_wr lo=100 hi=200 while idle, then sample 250 -> out_data=200; cfg_wr lo=9 hi=3 -> cfg_err=1, limits unchanged.
//  cfg_wr lo=0 hi=1000 in same cycle as accept of 50 -> out 22 (old limits); next sample 50 -> out 50.
//  Force sat_count to all-ones via CNT_W=4 build, 20 out-of-range samples -> sat_count=15; assert reset mid-burst -> all outputs reset values.

Source files
------------

// File: rtl/audio_clamp_scheduler.sv
// audio_clamp_scheduler: round-robin left/right sample scheduler for a shared clamp,
// with a one-entry output buffer, clamp limit configuration and saturation counter.
module audio_clamp_scheduler #(
    parameter int DATA_W = 32,
    parameter int DEF_LO = 11,
    parameter int DEF_HI = 22,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              l_valid,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_ready,
    input  logic              cfg_wr,
    input  logic [DATA_W-1:0] cfg_lo,
    input  logic [DATA_W-1:0] cfg_hi,
    output logic              cfg_err,
    output logic [DATA_W-1:0] clamp_in,
    output logic [DATA_W-1:0] clamp_lo,
    output logic [DATA_W-1:0] clamp_hi,
    input  logic [DATA_W-1:0] clamp_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_chan,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  sat_count
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               chan_q, chan_d;
    logic               pend_q, pend_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [DATA_W-1:0]  slo_q, slo_d, shi_q, shi_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   sat_q, sat_d;
    logic               slot_free, l_gnt, r_gnt, accept, cfg_ok, pend_eff;
    logic [DATA_W-1:0]  slo_eff, shi_eff;

    always_comb begin
        // Ready is gated by reset so nothing is accepted while reset is held.
        slot_free  = reset && (state_q == EMPTY || out_ready);
        l_gnt      = slot_free && l_valid && (!r_valid || last_q);
        r_gnt      = slot_free && r_valid && (!l_valid || !last_q);
        accept     = l_gnt || r_gnt;
        clamp_in   = r_gnt ? r_data : l_data;
        cfg_ok     = cfg_wr && (cfg_lo <= cfg_hi);
        pend_eff   = pend_q || cfg_ok;
        slo_eff    = cfg_ok ? cfg_lo : slo_q;
        shi_eff    = cfg_ok ? cfg_hi : shi_q;
        state_d    = accept ? FULL : (out_ready ? EMPTY : state_q);
        last_d     = accept ? r_gnt : last_q;
        chan_d     = accept ? r_gnt : chan_q;
        data_d     = accept ? clamp_out : data_q;
        sat_d      = (accept && clamp_out != clamp_in && sat_q != '1) ? sat_q + CNT_W'(1) : sat_q;
        err_d      = err_q || (cfg_wr && cfg_lo > cfg_hi);
        // Limits only move on an edge with no accept, so an in-flight sample never sees a mix.
        lo_d       = (pend_eff && !accept) ? slo_eff : lo_q;
        hi_d       = (pend_eff && !accept) ? shi_eff : hi_q;
        pend_d     = pend_eff && accept;
        slo_d      = slo_eff;
        shi_d      = shi_eff;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            chan_q  <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= DATA_W'(DEF_LO);
            hi_q    <= DATA_W'(DEF_HI);
            slo_q   <= DATA_W'(DEF_LO);
            shi_q   <= DATA_W'(DEF_HI);
            data_q  <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            slo_q   <= slo_d;
            shi_q   <= shi_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign l_ready   = l_gnt;
    assign r_ready   = r_gnt;
    assign clamp_lo  = lo_q;
    assign clamp_hi  = hi_q;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign sat_count = sat_q;
    assign cfg_err   = err_q;
endmodule
